// File: rtl/mp_add_seq.sv
// Sequential multi-word adder/subtractor: one 16-bit carry-select slice is
// reused across NUM_WORDS words, least-significant word first.

module csa_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum_c,
  output logic        cout_c
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  // Upper byte is computed for both carry values; the low byte's carry selects.
  always_comb begin
    lo     = 9'(a[7:0]) + 9'(b[7:0]) + 9'(cin);
    hi0    = 9'(a[15:8]) + 9'(b[15:8]);
    hi1    = 9'(a[15:8]) + 9'(b[15:8]) + 9'(1'b1);
    sum_c  = lo[8] ? {hi1[7:0], lo[7:0]} : {hi0[7:0], lo[7:0]};
    cout_c = lo[8] ? hi1[8] : hi0[8];
  end
endmodule

module mp_add_seq #(
  parameter  int unsigned NUM_WORDS = 4,
  localparam int unsigned W         = 16 * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic [NUM_WORDS-1:0][15:0]   a_q, a_d;
  logic [NUM_WORDS-1:0][15:0]   b_q, b_d;
  logic [NUM_WORDS-1:0][15:0]   sum_q, sum_d;
  logic                         cout_q, cout_d;
  logic                         ovf_q, ovf_d;
  logic                         done_q, done_d;
  logic                         busy_q, busy_d;
  logic                         ready_q, ready_d;

  logic [15:0] csa_sum;
  logic        csa_cout;

  csa_16bit u_csa (
    .a      (a_q[idx_q]),
    .b      (b_q[idx_q]),
    .cin    (carry_q),
    .sum_c  (csa_sum),
    .cout_c (csa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADD;
          a_d     = a;
          // Subtraction is a + ~b + 1: invert b here and force the carry in.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end
      end
      S_ADD: begin
        sum_d[idx_q] = csa_sum;
        carry_d      = csa_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
          cout_d  = csa_cout;
          ovf_d   = (a_q[NUM_WORDS-1][15] == b_q[NUM_WORDS-1][15]) &&
                    (csa_sum[15] != a_q[NUM_WORDS-1][15]);
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: a whole-width reference model predicts each
// result when an operation is launched; results are checked on every done pulse.

module tb_mp_add_seq;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned W         = 16 * NUM_WORDS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   last_done = -1;
  bit   b2b_mode  = 1'b0;
  exp_t sb[$];

  mp_add_seq #(.NUM_WORDS(NUM_WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic su);
    logic [W:0]   r;
    logic [W-1:0] bb;
    exp_t         e;
    bb     = su ? ~bv : bv;
    r      = {1'b0, av} + {1'b0, bb} + (W+1)'(su ? 1'b1 : ci);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (av[W-1] == bb[W-1]) && (r[W-1] != av[W-1]);
    return e;
  endfunction

  // Result monitor and handshake consistency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("ready_eq_nbusy", 64'(ready), 64'(!busy));
      if (done) begin
        chk("done_implies_busy", 64'(busy), 64'(1));
        chk("sb_nonempty_on_done", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", 64'(cout), 64'(e.cout));
          chk("ovf", 64'(ovf), 64'(e.ovf));
        end
        if (b2b_mode && last_done >= 0)
          chk("b2b_period", 64'(cyc - last_done), 64'(NUM_WORDS + 2));
        last_done = cyc;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'(1));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic su);
    int n;
    @(negedge clk);
    wait_ready();
    a = av; b = bv; cin = ci; sub = su; start = 1'b1;
    sb.push_back(model(av, bv, ci, su));
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs after acceptance; the result must not see them.
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    cin = 1'($urandom());
    sub = 1'($urandom());
    wait_done(n);
    chk("done_latency", 64'(n), 64'(NUM_WORDS));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", sum, 64'(0));
    chk("rst_cout_ovf", 64'({cout, ovf}), 64'(0));
    rst = 1'b0;

    // Directed cases from the requirements.
    do_op(64'h0, 64'h0, 1'b1, 1'b0);
    do_op(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    do_op(64'h5, 64'h7, 1'b1, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    chk("spec_sub_sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("spec_sub_flags", 64'({cout, ovf}), 64'(2'b11));

    // Start during ADD is ignored.
    @(negedge clk);
    wait_ready();
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b0; sub = 1'b0;
    start = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    a = 64'hDEAD_BEEF_0000_1111; b = 64'h2222_3333_4444_5555; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("ignore_done_latency", 64'(n), 64'(NUM_WORDS - 1));
    repeat (10) @(negedge clk);
    chk("ignore_no_extra_op", 64'(sb.size()), 64'(0));

    // Reset asserted across edge 2 of an operation aborts it.
    @(negedge clk);
    wait_ready();
    a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; cin = 1'b1; sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_sum", sum, 64'(0));
    chk("async_rst_ready", 64'(ready), 64'(1));
    chk("async_rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_abort_no_done_sum", sum, 64'(0));
    chk("rst_abort_ready", 64'(ready), 64'(1));
    do_op(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);

    // Back-to-back with start held high.
    b2b_mode  = 1'b1;
    last_done = -1;
    start     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_ready();
      a   = {$urandom(), $urandom()};
      b   = {$urandom(), $urandom()};
      cin = 1'($urandom());
      sub = 1'($urandom());
      sb.push_back(model(a, b, cin, sub));
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drained", 64'(sb.size()), 64'(0));
    @(negedge clk);
    b2b_mode = 1'b0;

    // Random operations.
    for (int k = 0; k < 10; k++)
      do_op({$urandom(), $urandom()}, {$urandom(), $urandom()},
            1'($urandom()), 1'($urandom()));

    repeat (5) @(negedge clk);
    chk("sb_final_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
